// File: rtl/adder4_pkg.sv
// adder4_pkg: shared operand/sum types, scheduler FSM states and stats counter width.
package adder4_pkg;
    typedef logic [3:0] operand_t;
    typedef logic [4:0] sum_t;
    typedef enum logic {IDLE, HOLD} state_e;
    localparam int STAT_W = 16;
endpackage

// File: rtl/adder4.sv
// adder4: 4-bit adder with carry-in and a 5-bit sum.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [4:0] sum
);
    assign sum = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: rtl/adder4_rr_sched_rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or above ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        idx = '0;
        // scan farthest-first so the candidate closest to ptr overwrites the rest
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k >= NUM_REQ) ? int'(ptr) + k - NUM_REQ : int'(ptr) + k;
            if (en && req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/adder4_rr_sched.sv
// adder4_rr_sched: round-robin sharing of one adder4 among NUM_REQ requesters, 1-cycle registered response.
// Define ADDER4_RR_SCHED_STATS_EN to add per-requester saturating grant counters (stat_clr/stat_grants).
module adder4_rr_sched
    import adder4_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [4:0]           resp_sum,
    output logic [ID_W-1:0]      resp_id
`ifdef ADDER4_RR_SCHED_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [STAT_W*NUM_REQ-1:0] stat_grants
`endif
);
    state_e state, state_nx;
    logic [ID_W-1:0] ptr, idx;
    logic [NUM_REQ-1:0] grant;
    logic acc_en, xfer, cin;
    operand_t a, b;
    sum_t sum;
    // gating with rst_n keeps req_ready low for the whole reset
    assign acc_en = rst_n && (!resp_valid || resp_ready);
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .en    (acc_en),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );
    assign req_ready = grant;
    assign xfer = |grant;
    assign a = xfer ? req_a[4*idx +: 4] : '0;
    assign b = xfer ? req_b[4*idx +: 4] : '0;
    assign cin = xfer ? req_cin[idx] : 1'b0;
    adder4 u_add (
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (sum)
    );
    assign resp_valid = state == HOLD;
    always_comb begin
        state_nx = state;
        state_nx = xfer ? HOLD : (state == HOLD && !resp_ready) ? HOLD : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            resp_sum <= '0;
            resp_id <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                resp_sum <= sum;
                resp_id <= idx;
                ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
            end
        end
    end
`ifdef ADDER4_RR_SCHED_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (stat_clr) cnt <= '0;
            else if (grant[i] && !(&cnt)) cnt <= cnt + 1'b1;
        end
        assign stat_grants[STAT_W*i +: STAT_W] = cnt;
    end
`endif
endmodule

// File: tb/tb_adder4_rr_sched.sv
// tb_adder4_rr_sched: directed vectors with hand-computed sums, ids and grants.
module tb_adder4_rr_sched;
    localparam int N = 4;
    logic clk, rst_n, resp_valid, resp_ready;
    logic [N-1:0] req_valid, req_ready, req_cin;
    logic [4*N-1:0] req_a, req_b;
    logic [4:0] resp_sum;
    logic [1:0] resp_id;
    int checks = 0;
    int errors = 0;
    int rot_sum[4] = '{1, 5, 7, 11};
`ifdef ADDER4_RR_SCHED_STATS_EN
    logic stat_clr;
    logic [16*N-1:0] stat_grants;
`endif

    adder4_rr_sched #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id)
`ifdef ADDER4_RR_SCHED_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_grants(stat_grants)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b, input int c);
        req_a[4*i +: 4] = 4'(a);
        req_b[4*i +: 4] = 4'(b);
        req_cin[i] = c[0];
    endtask

    initial begin
        rst_n = 0;
        req_valid = '1;
        resp_ready = 1;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
`ifdef ADDER4_RR_SCHED_STATS_EN
        stat_clr = 0;
`endif
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_sum", 32'(resp_sum), 0);
        chk("rst_id", 32'(resp_id), 0);
        @(negedge clk);
        rst_n = 1;
        req_valid = '0;
        #1 chk("idle_ready", 32'(req_ready), 0);
        // single request from 2
        @(negedge clk);
        set_op(2, 4, 5, 0);
        req_valid = 4'b0100;
        #1 chk("single_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        chk("single_valid", 32'(resp_valid), 1);
        chk("single_sum", 32'(resp_sum), 9);
        chk("single_id", 32'(resp_id), 2);
        req_valid = '0;
        @(negedge clk);
        chk("drain_valid", 32'(resp_valid), 0);
        // wrap arithmetic, ptr is 3 so requester 0 wins by wrap-around
        set_op(0, 15, 15, 1);
        req_valid = 4'b0001;
        #1 chk("wrap_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        chk("wrap31_sum", 32'(resp_sum), 31);
        chk("wrap31_id", 32'(resp_id), 0);
        set_op(1, 15, 3, 0);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("wrap18_sum", 32'(resp_sum), 18);
        chk("wrap18_id", 32'(resp_id), 1);
        set_op(3, 1, 2, 0);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("r3_sum", 32'(resp_sum), 3);
        chk("r3_id", 32'(resp_id), 3);
        // full contention from ptr=0
        for (int i = 0; i < N; i++) set_op(i, i + 1, 2 * i, i % 2);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rot_ready", 32'(req_ready), 32'(1 << (k % 4)));
            @(negedge clk);
            chk("rot_valid", 32'(resp_valid), 1);
            chk("rot_id", 32'(resp_id), 32'(k % 4));
            chk("rot_sum", 32'(resp_sum), 32'(rot_sum[k % 4]));
        end
        // backpressure with id0/sum1 pending, ptr=1
        resp_ready = 0;
        #1 chk("bp_ready0", 32'(req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 1);
            chk("bp_sum", 32'(resp_sum), 1);
            chk("bp_id", 32'(resp_id), 0);
            chk("bp_ready", 32'(req_ready), 0);
        end
        resp_ready = 1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        chk("bp_next_id", 32'(resp_id), 1);
        chk("bp_next_sum", 32'(resp_sum), 5);
        // asynchronous reset while holding a result
        #2 rst_n = 0;
        #1 chk("mid_rst_valid", 32'(resp_valid), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        chk("post_rst_id", 32'(resp_id), 0);
        chk("post_rst_sum", 32'(resp_sum), 1);
`ifdef ADDER4_RR_SCHED_STATS_EN
        req_valid = 4'b0010;
        repeat (3) @(negedge clk);
        chk("stat1_cnt", 32'(stat_grants[31:16]), 3);
        chk("stat0_cnt", 32'(stat_grants[15:0]), 1);
        stat_clr = 1;
        @(negedge clk);
        chk("stat_clr", 32'(stat_grants[31:16]), 0);
        stat_clr = 0;
`endif
        req_valid = '0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
